// File: rtl/note_pkg.sv
// Shared note-word definitions for the tone generator and the player/recorder
// blocks that produce 27-bit half-period note words.
package note_pkg;

    localparam int              NOTE_W           = 27;
    localparam logic [NOTE_W-1:0] NOTE_REST      = '0;
    localparam int              MIN_HALF_DEFAULT = 16;

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        RUN    = 2'd1,
        RETUNE = 2'd2
    } tone_state_e;

endpackage

// File: rtl/half_period_counter.sv
// Loadable up-counter that pulses tc_o on the last cycle of a period of half_i
// cycles and restarts from zero; load_i clears it.
module half_period_counter #(
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] half_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    assign tc_o = en_i && !load_i && (cnt_q == (half_i - WIDTH'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: plays a half-period note word on the speaker pin,
// applying note changes only on wave edges so no runt pulse is ever produced.
module note_tone_gen #(
    parameter int NOTE_W   = note_pkg::NOTE_W,
    parameter int MIN_HALF = note_pkg::MIN_HALF_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    input  logic              enable,
    output logic              speaker,
    output logic              active,
    output logic [NOTE_W-1:0] cur_half,
    output logic              edge_strb
);
    import note_pkg::*;

    tone_state_e       state_q, state_d;
    logic              speaker_q, speaker_d;
    logic              edge_q, edge_d;
    logic              stop_q, stop_d;
    logic [NOTE_W-1:0] cur_half_q, cur_half_d;
    logic [NOTE_W-1:0] req;
    logic              tc;
    logic              cnt_load;
    logic              cnt_en;

    // The pending note is simply the live request: the value present on the
    // edge cycle is the one that gets applied, so no separate latch is needed.
    always_comb begin
        req = '0;
        if (enable && note != '0) begin
            req = (note < NOTE_W'(MIN_HALF)) ? NOTE_W'(MIN_HALF) : note;
        end
    end

    assign cnt_load = (state_q == SILENT) || stop_q;
    assign cnt_en   = (state_q != SILENT);

    half_period_counter #(.WIDTH(NOTE_W)) u_counter (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (cnt_load),
        .en_i   (cnt_en),
        .half_i (cur_half_q),
        .tc_o   (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= SILENT;
            speaker_q  <= 1'b0;
            edge_q     <= 1'b0;
            stop_q     <= 1'b0;
            cur_half_q <= '0;
        end else begin
            state_q    <= state_d;
            speaker_q  <= speaker_d;
            edge_q     <= edge_d;
            stop_q     <= stop_d;
            cur_half_q <= cur_half_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SILENT: begin
                if (req != '0) state_d = RUN;
            end
            RUN, RETUNE: begin
                if (stop_q) begin
                    state_d = SILENT;
                end else if (tc) begin
                    if (req == '0) state_d = speaker_q ? RETUNE : SILENT;
                    else           state_d = RUN;
                end else if (req != cur_half_q) begin
                    state_d = RETUNE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = SILENT;
        endcase
    end

    always_comb begin
        speaker_d  = speaker_q;
        cur_half_d = cur_half_q;
        edge_d     = 1'b0;
        stop_d     = 1'b0;
        case (state_q)
            SILENT: begin
                speaker_d  = 1'b0;
                cur_half_d = '0;
                if (req != '0) begin
                    speaker_d  = 1'b1;
                    cur_half_d = req;
                    edge_d     = 1'b1;
                end
            end
            RUN, RETUNE: begin
                if (stop_q) begin
                    speaker_d  = 1'b0;
                    cur_half_d = '0;
                end else if (tc) begin
                    if (req == '0) begin
                        // A high half must finish with a low edge; a low half can stop as is.
                        if (speaker_q) begin
                            speaker_d = 1'b0;
                            edge_d    = 1'b1;
                            stop_d    = 1'b1;
                        end else begin
                            cur_half_d = '0;
                        end
                    end else begin
                        speaker_d  = ~speaker_q;
                        cur_half_d = req;
                        edge_d     = 1'b1;
                    end
                end
            end
            default: begin
                speaker_d  = 1'b0;
                cur_half_d = '0;
            end
        endcase
    end

    assign speaker   = speaker_q;
    assign edge_strb = edge_q;
    assign cur_half  = cur_half_q;
    assign active    = (state_q != SILENT);

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: start latency, half-period spacing,
// retune on edges, clamping, final low toggle, mute and asynchronous reset.
module tb_note_tone_gen;

    localparam int NOTE_W = 27;

    logic              clk = 1'b0;
    logic              reset;
    logic [NOTE_W-1:0] note;
    logic              enable;
    logic              speaker;
    logic              active;
    logic [NOTE_W-1:0] cur_half;
    logic              edge_strb;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    note_tone_gen #(.NOTE_W(NOTE_W), .MIN_HALF(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .note      (note),
        .enable    (enable),
        .speaker   (speaker),
        .active    (active),
        .cur_half  (cur_half),
        .edge_strb (edge_strb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for the next edge_strb (sampled on falling clk), bounded.
    task automatic wait_edge(input string tag, output int t);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (edge_strb !== 1'b1 && n < 300);
        check({tag, "_edge_seen"}, 32'(edge_strb), 32'd1);
        t = cyc;
    endtask

    initial begin
        int t0, t1, bad, edges;

        reset  = 1'b0;
        note   = '0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_speaker",  32'(speaker),   32'd0);
        check("rst_active",   32'(active),    32'd0);
        check("rst_cur_half", 32'(cur_half),  32'd0);
        check("rst_edge",     32'(edge_strb), 32'd0);

        // Rest for 100 cycles after release
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (speaker !== 1'b0 || active !== 1'b0 || cur_half !== '0 || edge_strb !== 1'b0) bad++;
        end
        check("rest_window_bad_cycles", 32'(bad), 32'd0);

        // Start note 20
        note = 27'd20;
        @(negedge clk);
        check("start20_speaker",  32'(speaker),   32'd1);
        check("start20_edge",     32'(edge_strb), 32'd1);
        check("start20_active",   32'(active),    32'd1);
        check("start20_cur_half", 32'(cur_half),  32'd20);
        t0 = cyc;
        wait_edge("h20a", t1);
        check("h20a_spacing", 32'(t1 - t0), 32'd20);
        check("h20a_speaker", 32'(speaker), 32'd0);
        t0 = t1;
        wait_edge("h20b", t1);
        check("h20b_spacing", 32'(t1 - t0), 32'd20);
        check("h20b_speaker", 32'(speaker), 32'd1);
        t0 = t1;

        // Retune to 50 seven cycles into a half
        repeat (7) @(negedge clk);
        note = 27'd50;
        wait_edge("r50a", t1);
        check("r50a_spacing",  32'(t1 - t0), 32'd20);
        check("r50a_cur_half", 32'(cur_half), 32'd50);
        check("r50a_speaker",  32'(speaker), 32'd0);
        t0 = t1;
        wait_edge("r50b", t1);
        check("r50b_spacing", 32'(t1 - t0), 32'd50);
        check("r50b_speaker", 32'(speaker), 32'd1);
        t0 = t1;

        // Note 5 clamps to 16
        note = 27'd5;
        wait_edge("c16a", t1);
        check("c16a_spacing",  32'(t1 - t0), 32'd50);
        check("c16a_cur_half", 32'(cur_half), 32'd16);
        t0 = t1;
        wait_edge("c16b", t1);
        check("c16b_spacing", 32'(t1 - t0), 32'd16);
        check("c16b_speaker", 32'(speaker), 32'd1);
        t0 = t1;

        // Rest while high: one final low toggle, then silent
        note = '0;
        wait_edge("stop", t1);
        check("stop_spacing", 32'(t1 - t0), 32'd16);
        check("stop_speaker", 32'(speaker), 32'd0);
        check("stop_active",  32'(active),  32'd1);
        @(negedge clk);
        check("silent_active",   32'(active),   32'd0);
        check("silent_cur_half", 32'(cur_half), 32'd0);
        check("silent_speaker",  32'(speaker),  32'd0);

        // Play 30, detour to 40 and back inside one half
        note = 27'd30;
        @(negedge clk);
        check("start30_edge", 32'(edge_strb), 32'd1);
        t0 = cyc;
        repeat (5) @(negedge clk);
        note = 27'd40;
        repeat (5) @(negedge clk);
        note = 27'd30;
        wait_edge("c30a", t1);
        check("c30a_spacing",  32'(t1 - t0), 32'd30);
        check("c30a_cur_half", 32'(cur_half), 32'd30);
        t0 = t1;
        wait_edge("c30b", t1);
        check("c30b_spacing", 32'(t1 - t0), 32'd30);
        check("c30b_speaker", 32'(speaker), 32'd1);

        // Asynchronous reset mid-half while high
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_speaker",  32'(speaker),  32'd0);
        check("arst_active",   32'(active),   32'd0);
        check("arst_cur_half", 32'(cur_half), 32'd0);
        note = 27'd25;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("start25_speaker",  32'(speaker),   32'd1);
        check("start25_edge",     32'(edge_strb), 32'd1);
        check("start25_cur_half", 32'(cur_half),  32'd25);
        t0 = cyc;
        wait_edge("h25", t1);
        check("h25_spacing", 32'(t1 - t0), 32'd25);
        check("h25_speaker", 32'(speaker), 32'd0);

        // Mute during a low half: silent at the half end with no toggle
        enable = 1'b0;
        edges = 0;
        repeat (24) begin
            @(negedge clk);
            if (edge_strb === 1'b1) edges++;
        end
        check("mute_active_before_end", 32'(active), 32'd1);
        @(negedge clk);
        if (edge_strb === 1'b1) edges++;
        check("mute_active_after_end", 32'(active),   32'd0);
        check("mute_speaker",          32'(speaker),  32'd0);
        check("mute_cur_half",         32'(cur_half), 32'd0);
        check("mute_no_edges",         32'(edges),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Consumer end of the player's 27-bit note stream: takes the note word read out of note memory and drives a 1-bit square wave for the speaker/PWM pin.
- A note word is a half-period length in clk cycles; 0 means rest (silence).
- New notes are applied only on a wave edge, so retuning never produces a runt pulse.
- Sits between the player's note output and the board audio pin.

Parameters:
- NOTE_W, 27, width of note word (half-period count).
- MIN_HALF, 16, smallest legal nonzero half-period; nonzero notes below this are clamped up to MIN_HALF.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- note  input  NOTE_W  requested half-period in clk cycles; 0 = rest; synchronous to clk.
- enable  input  1  1 = play; 0 = mute request, handled like note=0.
- speaker  output  1  square-wave output.
- active  output  1  1 while the generator is in RUN or RETUNE.
- cur_half  output  NOTE_W  half-period currently in effect; 0 when silent.
- edge_strb  output  1  one-cycle pulse on every speaker toggle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=SILENT; speaker=0, active=0, cur_half=0, edge_strb=0, cnt=0.
  - Reset release is synchronous to clk.
  - Reset asserted mid-note forces everything to the reset values immediately.
- Effective request: req = (enable && note!=0) ? max(note, MIN_HALF) : 0, computed combinationally each cycle.
- Counter cnt (NOTE_W bits):
  - In RUN/RETUNE, cnt increments every cycle.
  - When cnt == cur_half-1, the current half-period ends: cnt clears to 0, speaker toggles, edge_strb=1 for that cycle.
  - So each half-period lasts exactly cur_half cycles.
  - Never wraps: cur_half >= MIN_HALF, and cur_half is at most 2^NOTE_W-1, so cnt stays within NOTE_W bits.
- States:
  - SILENT:
    - speaker held 0, cnt=0.
    - If req != 0: next cycle cur_half=req, speaker=1, edge_strb=1, active=1, go RUN. Start latency is 1 cycle.
  - RUN:
    - If req == cur_half: keep counting.
    - If req != cur_half (including req=0): go RETUNE, capturing req into pend register.
  - RETUNE:
    - Keeps counting with the old cur_half.
    - pend is refreshed every cycle from req, so the last value before the edge wins.
    - At half-period end:
      - If pend == 0 and speaker is currently 1: toggle to 0 and stay in RETUNE (a final low half is not required); on the next cycle go SILENT with cur_half=0, active=0.
      - If pend == 0 and speaker is currently 0: go SILENT directly without toggling.
      - If pend != 0: toggle speaker, load cur_half=pend, cnt=0, go RUN.
    - If req returns to cur_half before the edge: cancel, go back to RUN with no change.
- Simultaneous events:
  - A note change in the same cycle as a half-period end takes effect at that edge. Both the toggle and the new cur_half apply in that cycle.
  - enable falling on an edge cycle is treated the same as note=0 on that cycle.
- Guarantees:
  - No speaker high pulse is ever shorter than MIN_HALF cycles.
  - speaker is 0 whenever state=SILENT.
  - Outputs are registered; no combinational path from inputs to speaker.

Decomposition:
- Package note_pkg:
  - NOTE_W=27.
  - NOTE_REST=0.
  - Default MIN_HALF.
  - State enum {SILENT, RUN, RETUNE} (2-bit encoding).
  - Shared with the player/recorder blocks that produce note words.
- One natural sub-module: half_period_counter.
  - Loadable NOTE_W counter with a terminal-count pulse, cleared on load.
  - Also reusable by the player's tempo divider.
- The FSM, clamping and speaker flop stay in note_tone_gen.

Test Plan:
- Reset release, note=0, enable=1 for 100 cycles -> speaker=0, active=0, cur_half=0, no edge_strb.
- note=20, enable=1 from SILENT -> speaker rises 1 cycle later, then toggles every 20 cycles; edge_strb pulses are 20 cycles apart; cur_half=20.
- Playing 20, change note to 50 at 7 cycles into a half -> the current half still lasts 20 cycles; subsequent halves last 50; no half shorter than 20.
- note=5 with MIN_HALF=16 -> cur_half=16, halves of 16 cycles; note=0 while speaker=1 -> one final toggle to 0 at the half end, then SILENT, active=0.
- Playing 30, change to 40 then back to 30 within the same half -> no period change; edge spacing stays 30.
- Assert reset mid-half (speaker=1) -> speaker=0, active=0, cur_half=0 asynchronously, before the next clk edge; after release with note=25, restart with 1-cycle latency and 25-cycle halves.
